// File: rtl/sort4_feeder_pkg.sv
// Shared configuration for the 4-word sort feeder: data width, pad word,
// FSM state encodings and the sorter latency the feeder is built around.
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 16
`endif

package sort4_feeder_pkg;

  localparam int DW_DEFAULT = `OUTPUT_BUF_DATASIZE;

  // Unused slots are padded with all-ones so they sort above every real word.
  localparam logic [DW_DEFAULT-1:0] PAD_DEFAULT = {DW_DEFAULT{1'b1}};

  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_SORT    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_OUT     = 2'd3;

  localparam int SORT_LAT = 7;

endpackage

// File: rtl/sort4_feeder.sv
// Collects up to four words, hands them to an external 4-input sorter, then
// streams the real (non-padded) results out in ascending order.
module sort4_feeder
  import sort4_feeder_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int WDOG = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          sort_en,
  output logic [DW-1:0] sort_in1,
  output logic [DW-1:0] sort_in2,
  output logic [DW-1:0] sort_in3,
  output logic [DW-1:0] sort_in4,
  input  logic          sort_finish,
  input  logic [DW-1:0] sort_small1,
  input  logic [DW-1:0] sort_small2,
  input  logic [DW-1:0] sort_large1,
  input  logic [DW-1:0] sort_large2,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [DW-1:0] m_max,
  output logic          busy,
  output logic          err_wdog
);

  localparam int WW = $clog2(WDOG + 1);
  localparam logic [DW-1:0] PAD = {DW{1'b1}};

  logic [1:0]    state;
  logic [2:0]    cnt;
  logic [2:0]    nvalid;
  logic [1:0]    idx;
  logic [WW-1:0] wdog_cnt;
  logic [DW-1:0] slot [4];
  logic [DW-1:0] res  [4];
  logic          s_fire;
  logic          m_fire;

  // Largest real word is the last ascending result that is not padding.
  function automatic logic [DW-1:0] pick_max(input logic [2:0] n,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic [DW-1:0] c,
                                             input logic [DW-1:0] d);
    case (n)
      3'd1:    pick_max = a;
      3'd2:    pick_max = b;
      3'd3:    pick_max = c;
      default: pick_max = d;
    endcase
  endfunction

  assign s_ready  = (state == ST_FILL);
  assign busy     = (state != ST_FILL);
  assign m_valid  = (state == ST_OUT);
  assign s_fire   = s_valid & s_ready;
  assign m_fire   = m_valid & m_ready;
  assign sort_in1 = slot[0];
  assign sort_in2 = slot[1];
  assign sort_in3 = slot[2];
  assign sort_in4 = slot[3];
  assign m_data   = res[idx];
  assign m_last   = (state == ST_OUT) && ({1'b0, idx} == (nvalid - 3'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FILL;
      cnt      <= '0;
      nvalid   <= '0;
      idx      <= '0;
      wdog_cnt <= '0;
      sort_en  <= 1'b0;
      m_max    <= '0;
      err_wdog <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        slot[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      case (state)
        ST_FILL: begin
          if (s_fire) begin
            slot[cnt[1:0]] <= s_data;
            cnt            <= cnt + 3'd1;
            if (cnt == 3'd3 || s_last) begin
              for (int i = 0; i < 4; i++) begin
                if (i > int'(cnt)) slot[i] <= PAD;
              end
              nvalid   <= cnt + 3'd1;
              wdog_cnt <= '0;
              sort_en  <= 1'b1;
              state    <= ST_SORT;
            end
          end
        end
        // A finish on the watchdog's final cycle still counts as success.
        ST_SORT: begin
          if (sort_finish) begin
            sort_en <= 1'b0;
            state   <= ST_CAPTURE;
          end else if (wdog_cnt == WW'(WDOG - 1)) begin
            err_wdog <= 1'b1;
            sort_en  <= 1'b0;
            cnt      <= '0;
            state    <= ST_FILL;
          end else begin
            wdog_cnt <= wdog_cnt + WW'(1);
          end
        end
        ST_CAPTURE: begin
          res[0] <= sort_small1;
          res[1] <= sort_small2;
          res[2] <= sort_large1;
          res[3] <= sort_large2;
          m_max  <= pick_max(nvalid, sort_small1, sort_small2, sort_large1, sort_large2);
          idx    <= '0;
          state  <= ST_OUT;
        end
        ST_OUT: begin
          if (m_fire) begin
            if (m_last) begin
              cnt   <= '0;
              idx   <= '0;
              state <= ST_FILL;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_feeder.sv
// Directed bench for sort4_feeder with a behavioural 7-cycle 4-input sorter.
module tb_sort4_feeder;

  localparam int DW = sort4_feeder_pkg::DW_DEFAULT;
  localparam logic [DW-1:0] PAD = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          sort_en;
  logic [DW-1:0] sort_in1, sort_in2, sort_in3, sort_in4;
  logic          sort_finish;
  logic [DW-1:0] sort_small1, sort_small2, sort_large1, sort_large2;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [DW-1:0] m_max;
  logic          busy;
  logic          err_wdog;

  int n_cmp = 0;
  int n_bad = 0;
  bit sorter_ok = 1'b1;

  always #5 clk = ~clk;

  sort4_feeder #(.DW(DW), .WDOG(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .sort_en(sort_en), .sort_in1(sort_in1), .sort_in2(sort_in2),
    .sort_in3(sort_in3), .sort_in4(sort_in4),
    .sort_finish(sort_finish), .sort_small1(sort_small1), .sort_small2(sort_small2),
    .sort_large1(sort_large1), .sort_large2(sort_large2),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_max(m_max), .busy(busy), .err_wdog(err_wdog)
  );

  // Behavioural sorter: finish is raised on the 7th cycle of sort_en.
  int scnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) scnt <= 0;
    else if (!sort_en) scnt <= 0;
    else if (!sort_finish) scnt <= scnt + 1;
  end
  assign sort_finish = sorter_ok && sort_en && (scnt == 6);

  logic [DW-1:0] srt [4];
  always_comb begin
    logic [DW-1:0] tmp;
    tmp = '0;
    srt[0] = sort_in1; srt[1] = sort_in2; srt[2] = sort_in3; srt[3] = sort_in4;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (srt[j] > srt[j+1]) begin
          tmp = srt[j]; srt[j] = srt[j+1]; srt[j+1] = tmp;
        end
  end
  assign sort_small1 = srt[0];
  assign sort_small2 = srt[1];
  assign sort_large1 = srt[2];
  assign sort_large2 = srt[3];

  typedef struct packed {
    logic [2:0]         n;
    logic [3:0][DW-1:0] w;
    logic [3:0][DW-1:0] exp;
    logic [DW-1:0]      exp_max;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_group(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = v.w[i];
      s_last  = (i == int'(v.n) - 1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    chk("sort_en_set", sort_en, 1);
    chk("s_ready_sort", s_ready, 0);
    chk("sort_in1", sort_in1, (v.n > 0) ? v.w[0] : PAD);
    chk("sort_in2", sort_in2, (v.n > 1) ? v.w[1] : PAD);
    chk("sort_in3", sort_in3, (v.n > 2) ? v.w[2] : PAD);
    chk("sort_in4", sort_in4, (v.n > 3) ? v.w[3] : PAD);
  endtask

  task automatic wait_valid();
    int k;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (m_valid) break;
    end
    chk("latency", k, 8);
  endtask

  task automatic drain(input vec_t v);
    for (int b = 0; b < int'(v.n); b++) begin
      chk("m_valid", m_valid, 1);
      chk("m_data", m_data, v.exp[b]);
      chk("m_last", m_last, (b == int'(v.n) - 1));
      chk("m_max", m_max, v.exp_max);
      chk("s_ready_out", s_ready, 0);
      @(posedge clk);
      #1;
    end
    chk("m_valid_done", m_valid, 0);
    chk("s_ready_done", s_ready, 1);
  endtask

  vec_t tbl [4];
  vec_t v_bp, v_wd, v_rs;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{n: 3'd4, w: {16'd1, 16'd9, 16'd3, 16'd5},
               exp: {16'd9, 16'd5, 16'd3, 16'd1}, exp_max: 16'd9};
    tbl[1] = '{n: 3'd2, w: {16'd0, 16'd0, 16'd2, 16'd7},
               exp: {PAD, PAD, 16'd7, 16'd2}, exp_max: 16'd7};
    tbl[2] = '{n: 3'd1, w: {16'd0, 16'd0, 16'd0, 16'd4},
               exp: {PAD, PAD, PAD, 16'd4}, exp_max: 16'd4};
    tbl[3] = '{n: 3'd2, w: {16'd0, 16'd0, 16'd0, 16'hFFFF},
               exp: {PAD, PAD, 16'hFFFF, 16'd0}, exp_max: 16'hFFFF};
    v_bp = '{n: 3'd4, w: {16'd2, 16'd4, 16'd6, 16'd8},
             exp: {16'd8, 16'd6, 16'd4, 16'd2}, exp_max: 16'd8};
    v_wd = '{n: 3'd2, w: {16'd0, 16'd0, 16'd2, 16'd1},
             exp: '0, exp_max: '0};
    v_rs = '{n: 3'd4, w: {16'd1, 16'd0, 16'd3, 16'd3},
             exp: {16'd3, 16'd3, 16'd1, 16'd0}, exp_max: 16'd3};

    // Reset state
    #12;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_sort_en", sort_en, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_max", m_max, 0);
    chk("rst_err_wdog", err_wdog, 0);
    chk("rst_sort_in1", sort_in1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      send_group(tbl[t]);
      chk("busy_sort", busy, 1);
      wait_valid();
      drain(tbl[t]);
    end

    // Backpressure: first beat held for 5 cycles.
    m_ready = 1'b0;
    send_group(v_bp);
    wait_valid();
    for (int c = 0; c < 5; c++) begin
      chk("bp_m_data", m_data, 2);
      chk("bp_m_last", m_last, 0);
      chk("bp_m_max", m_max, 8);
      chk("bp_s_ready", s_ready, 0);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    drain(v_bp);

    // Watchdog: sorter never finishes.
    sorter_ok = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      send_group(v_wd);
      for (int k = 1; k <= 15; k++) begin
        @(posedge clk);
        #1;
        if (m_valid) seen = 1'b1;
        if (k == 14) chk("wdog_pre", err_wdog, 0);
      end
      chk("wdog_err", err_wdog, 1);
      chk("wdog_fill", s_ready, 1);
      chk("wdog_sort_en", sort_en, 0);
      chk("wdog_no_valid", seen, 0);
    end
    sorter_ok = 1'b1;
    send_group(tbl[0]);
    wait_valid();
    drain(tbl[0]);
    chk("wdog_sticky", err_wdog, 1);

    // Reset during OUT after the first beat.
    send_group(tbl[0]);
    wait_valid();
    chk("rs_beat0", m_data, 1);
    @(posedge clk);
    #1;
    chk("rs_mid_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_m_valid", m_valid, 0);
    chk("rs_sort_en", sort_en, 0);
    chk("rs_m_data", m_data, 0);
    chk("rs_m_max", m_max, 0);
    chk("rs_err_clr", err_wdog, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_post_valid", m_valid, 0);
    chk("rs_post_ready", s_ready, 1);
    send_group(v_rs);
    wait_valid();
    drain(v_rs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
